// File: rtl/sensor_pkg.sv
// sensor_pkg: shared state encoding, colour-bar palette and pixel packing for the DVP sensor model.
package sensor_pkg;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  localparam logic [15:0] BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };
  function automatic logic [15:0] rgb888_to_565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction
endpackage

// File: rtl/sensor_timing_gen.sv
// sensor_timing_gen: frame FSM, line/row counters, registered vsync/href and per-pixel load strobes.
module sensor_timing_gen
  import sensor_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 16,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic        pix_load_o,
  output logic        byte_lo_o,
  output logic        frame_start_o,
  output logic        frame_done_o,
  output logic [10:0] pix_idx_o
);
  localparam int L = 2 * H_ACTIVE + H_BLANK;
  state_t      st_q, st_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic        vsync_q, vsync_d, href_q, href_d;
  logic        line_end, last_line;
  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    line_end  = h_q == 12'(L - 1);
    last_line = v_q == 12'(st_q == VSYNC ? VSYNC_LINES - 1 : st_q == VBACK ? V_BACK - 1 :
                           st_q == ACTIVE ? V_ACTIVE - 1 : V_FRONT - 1);
    st_d = st_q;
    h_d  = line_end ? 12'd0 : h_q + 12'd1;
    v_d  = line_end ? (last_line ? 12'd0 : v_q + 12'd1) : v_q;
    if (st_q == IDLE) begin
      st_d = en_i ? VSYNC : IDLE;
      h_d  = 12'd0;
      v_d  = 12'd0;
    end else if (line_end && last_line)
      st_d = st_q == VSYNC ? VBACK : st_q == VBACK ? ACTIVE : st_q == ACTIVE ? VFRONT :
             en_i ? VSYNC : IDLE;
    href_d        = st_d == ACTIVE && h_d < 12'(2 * H_ACTIVE);
    vsync_d       = st_d == VSYNC;
    pix_load_o    = href_d && !h_d[0];
    byte_lo_o     = href_d && h_d[0];
    pix_idx_o     = h_d[11:1];
    frame_start_o = st_d == VSYNC && (st_q == IDLE || st_q == VFRONT);
    frame_done_o  = st_q == VFRONT && line_end && last_line;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q    <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
    end
  assign vsync_o = vsync_q;
  assign href_o  = href_q;
endmodule

// File: rtl/sensor_encode.sv
// sensor_encode: DVP transmitter emitting RGB565 bytes from an RGB888 stream or internal colour bars.
module sensor_encode
  import sensor_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 16,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 8,
  parameter int V_FRONT     = 4
) (
  input  logic        cmos_pclk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        pattern_en_i,
  input  logic [23:0] pix_rgb_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic        cmos_vsync_o,
  output logic        cmos_href_o,
  output logic [7:0]  cmos_data_o,
  output logic [15:0] frame_cnt_o,
  output logic        underflow_o
);
  localparam int BAR_W = H_ACTIVE / 8;
  logic        pix_load, byte_lo, frame_start, frame_done;
  logic [10:0] pix_idx;
  logic        mode_q, mode_d, uf_q, uf_d;
  logic [7:0]  data_q, data_d, lo_q, lo_d;
  logic [15:0] fc_q, fc_d, pix;
  sensor_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk(cmos_pclk_i), .rst_n(rst_n_i), .en_i(enable_i),
    .vsync_o(cmos_vsync_o), .href_o(cmos_href_o),
    .pix_load_o(pix_load), .byte_lo_o(byte_lo),
    .frame_start_o(frame_start), .frame_done_o(frame_done), .pix_idx_o(pix_idx)
  );
  // The low byte of each pixel is parked in lo_q for the cycle after its high byte.
  always_comb begin
    pix_ready_o = pix_load && !mode_q;
    pix    = mode_q ? BAR_COLORS[3'(pix_idx / 11'(BAR_W))] :
             pix_valid_i ? rgb888_to_565(pix_rgb_i) : 16'h0000;
    data_d = pix_load ? pix[15:8] : byte_lo ? lo_q : 8'h00;
    lo_d   = pix_load ? pix[7:0] : lo_q;
    mode_d = frame_start ? pattern_en_i : mode_q;
    uf_d   = uf_q | (pix_ready_o & ~pix_valid_i);
    fc_d   = fc_q + 16'(frame_done);
  end
  always_ff @(posedge cmos_pclk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      mode_q <= 1'b0;
      uf_q   <= 1'b0;
      data_q <= '0;
      lo_q   <= '0;
      fc_q   <= '0;
    end else begin
      mode_q <= mode_d;
      uf_q   <= uf_d;
      data_q <= data_d;
      lo_q   <= lo_d;
      fc_q   <= fc_d;
    end
  assign cmos_data_o = data_q;
  assign frame_cnt_o = fc_q;
  assign underflow_o = uf_q;
endmodule

// File: tb/tb_sensor_encode.sv
// tb_sensor_encode: randomized bench comparing sensor_encode to a frame-position reference model.
module tb_sensor_encode;
  localparam int HA = 8, HB = 4, VA = 2, VS = 1, VB = 1, VF = 1;
  localparam int L = 2 * HA + HB, FRAME = L * (VS + VB + VA + VF);
  logic clk = 0, rst_n = 0, en = 0, pat = 0, valid = 0;
  logic [23:0] rgb = '0;
  logic ready, vsync, href, uf;
  logic [7:0] data;
  logic [15:0] fc;
  int tests = 0, fails = 0, rdy_cnt = 0;
  bit m_run, m_mode, m_uf, collect;
  int m_pos;
  logic [15:0] m_fc, m_pix;
  logic [7:0] got_q[$];
  logic [15:0] bars[8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0] line1[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                            8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  sensor_encode #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
    .cmos_pclk_i(clk), .rst_n_i(rst_n), .enable_i(en), .pattern_en_i(pat),
    .pix_rgb_i(rgb), .pix_valid_i(valid), .pix_ready_o(ready),
    .cmos_vsync_o(vsync), .cmos_href_o(href), .cmos_data_o(data),
    .frame_cnt_o(fc), .underflow_o(uf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit act(int pos);
    int ln = pos / L;
    return ln >= VS + VB && ln < VS + VB + VA && pos % L < 2 * HA;
  endfunction

  function automatic logic [15:0] to565(logic [23:0] c);
    return 16'((c[23:16] >> 3) * 2048 + (c[15:8] >> 2) * 32 + (c[7:0] >> 3));
  endfunction

  task automatic model_reset();
    m_run = 0; m_mode = 0; m_uf = 0; m_pos = 0; m_fc = 0;
  endtask

  task automatic cyc(input bit e, input bit p, input bit v, input logic [23:0] c);
    bit nrun, nmode, rdy, exp_href;
    int npos;
    @(negedge clk);
    en = e; pat = p; valid = v; rgb = c;
    #1;
    nrun = m_run; npos = m_pos + 1; nmode = m_mode;
    if (!m_run) begin
      nrun = e; npos = 0; nmode = p;
    end else if (npos == FRAME) begin
      m_fc++;
      nrun = e; npos = 0; nmode = e ? p : m_mode;
    end
    rdy = nrun && !nmode && act(npos) && npos % 2 == 0;
    chk("pix_ready", ready, rdy);
    if (rdy) rdy_cnt++;
    if (nrun && act(npos) && npos % 2 == 0)
      m_pix = nmode ? bars[(npos % L) / 2 / (HA / 8)] : (v ? to565(c) : 16'h0000);
    if (rdy && !v) m_uf = 1;
    @(posedge clk);
    m_run = nrun; m_pos = npos; m_mode = nmode;
    #1;
    exp_href = m_run && act(m_pos);
    chk("vsync", vsync, m_run && m_pos < VS * L);
    chk("href", href, exp_href);
    chk("data", data, !exp_href ? 8'h00 : m_pos % 2 == 0 ? m_pix[15:8] : m_pix[7:0]);
    chk("frame_cnt", fc, m_fc);
    chk("underflow", uf, m_uf);
    if (collect && href) got_q.push_back(data);
  endtask

  initial begin
    int vs_i, href_i, n;
    bit en_r, pat_r;
    logic [15:0] fc0;
    model_reset();
    #3;
    chk("reset_outs", {ready, vsync, href, data, fc, uf}, 0);
    #4 rst_n = 1;
    // Pattern frame: timing and colour bars
    vs_i = -1; href_i = -1; collect = 1;
    for (int i = 0; i < 105; i++) begin
      cyc(1, 1, 0, 24'h0);
      if (vsync && vs_i < 0) vs_i = i;
      if (href && href_i < 0) href_i = i;
    end
    collect = 0;
    chk("vsync_first", vs_i, 0);
    chk("href_delay", href_i - vs_i, 40);
    chk("frame1_cnt", fc, 1);
    for (int i = 0; i < 16; i++) chk("bar_byte", got_q[i], line1[i]);
    // Upstream stream with a constant pixel
    repeat (96) cyc(1, 0, 1, 24'h12F4A8);
    rdy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, 1, 24'h12F4A8);
      if (m_pos == 40) chk("stream_hi", data, 8'h17);
      if (m_pos == 41) chk("stream_lo", data, 8'hB5);
    end
    chk("stream_rdy_cnt", rdy_cnt, 16);
    chk("stream_no_uf", uf, 0);
    // Missing pixel on the third ready cycle of the first active line
    for (int i = 0; i < 100; i++) begin
      cyc(1, 0, !(m_run && m_pos == 43), $urandom);
      if (m_pos == 44) chk("uf_pix_hi", data, 8'h00);
      if (m_pos == 45) chk("uf_pix_lo", data, 8'h00);
      if (m_pos == 55) chk("uf_href_width", href, 1);
      if (m_pos == 56) chk("uf_href_end", href, 0);
    end
    chk("uf_sticky", uf, 1);
    // Random traffic with mode and enable changes
    en_r = 1; pat_r = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 79) == 0) en_r = ~en_r;
      if ($urandom_range(0, 49) == 0) pat_r = ~pat_r;
      cyc(en_r, pat_r, $urandom_range(0, 15) != 0, $urandom);
    end
    // Enable drop during the first active line
    n = 0;
    while (!(m_run && m_pos == 45) && n < 300) begin
      cyc(1, 0, 1, $urandom);
      n++;
    end
    chk("drop_reach_active", n < 300, 1);
    fc0 = m_fc;
    repeat (120) cyc(0, 0, 1, $urandom);
    chk("drop_fc", fc, fc0 + 16'd1);
    chk("drop_idle", {ready, vsync, href, data}, 0);
    // Asynchronous reset in the middle of href
    n = 0;
    while (!(m_run && m_pos == 45) && n < 300) begin
      cyc(1, 1, 1, $urandom);
      n++;
    end
    chk("rst_reach_active", n < 300, 1);
    chk("rst_pre_href", href, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_async_outs", {ready, vsync, href, data, fc, uf}, 0);
    model_reset();
    #1 rst_n = 1;
    cyc(1, 0, 1, $urandom);
    chk("vsync_after_rst", vsync, 1);
    repeat (150) cyc(1, $urandom_range(0, 1), $urandom_range(0, 7) != 0, $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
